// File: rtl/piso_shift_out.sv
// piso_shift_out: parallel-in / serial-out stage behind the 8-bit SR register.
// A word is captured with a load_valid/load_ready handshake. It is then
// streamed out one bit per accepted cycle with a sout_valid/sout_ready
// handshake. If the next load is offered on the edge that accepts the last
// bit, the next word starts without a bubble.
// sout, sout_valid, busy and done come from flops. load_ready is combinational
// and is held low while rst_n is asserted.
module piso_shift_out #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer;
  logic             last_bit;
  logic             load_ready_c;

  // Reorder a captured word so that the bit to send first sits at index 0.
  // The shift register then only ever shifts right.
  function automatic logic [WIDTH-1:0] order_word(input logic [0:WIDTH-1] w);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LSB_FIRST != 0) begin
        r[i] = w[WIDTH-1-i];
      end else begin
        r[i] = w[i];
      end
    end
    return r;
  endfunction

  // Next-state logic: handles capture, the per-bit transfer, and the
  // wrap/reload on the last bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    done_d       = 1'b0;
    load_ready_c = 1'b0;
    xfer         = (state_q == SHIFT) && sout_ready;
    last_bit     = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        load_ready_c = 1'b1;
        if (load_valid) begin
          shreg_d = order_word(d);
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        load_ready_c = last_bit && sout_ready;
        if (xfer) begin
          if (last_bit) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (load_valid) begin
              // Back-to-back: the next word replaces the finished one with no gap.
              shreg_d = order_word(d);
              state_d = SHIFT;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end else begin
          // Stalled by the consumer: hold the bit position and the data.
          cnt_d   = cnt_q;
          shreg_d = shreg_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase

    // Registered outputs show the next state, so the first bit appears in
    // the cycle right after the load is accepted.
    sout_valid_d = (state_d == SHIFT);
    busy_d       = (state_d == SHIFT);
    if (state_d == SHIFT) begin
      sout_d = shreg_d[0];
    end else begin
      sout_d = 1'b0;
    end
  end

  // State, counter, data and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign load_ready = rst_n & load_ready_c;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_out.sv
// Bench for piso_shift_out. It runs both bit orders side by side on shared
// stimulus. A scoreboard monitor queues the expected serial bits whenever a
// load is accepted, and checks each bit as it is transferred. Each scenario
// task checks timing, handshakes and the packed word it sees.
module tb_piso_shift_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [0:7] d = 8'h00;
  logic       load_valid = 1'b0;
  logic       sout_ready = 1'b0;

  logic load_ready_m, sout_m, sout_valid_m, busy_m, done_m;
  logic load_ready_l, sout_l, sout_valid_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        exp_m[$];
  logic        exp_l[$];
  logic [15:0] log_m = 16'h0000;
  logic [15:0] log_l = 16'h0000;
  int          log_n = 0;
  int          done_log[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  piso_shift_out #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
    .load_ready(load_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
    .sout_ready(sout_ready), .busy(busy_m), .done(done_m)
  );

  piso_shift_out #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
    .load_ready(load_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
    .sout_ready(sout_ready), .busy(busy_l), .done(done_l)
  );

  // Scoreboard: push the expected bit order on each accepted load and pop one
  // entry on each serial transfer.
  task automatic monitor();
    logic e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (load_valid && load_ready_m) begin
          for (int i = 0; i < 8; i++) begin
            exp_m.push_back(d[i]);
            exp_l.push_back(d[7-i]);
          end
        end
        checks++;
        if (load_ready_l !== load_ready_m) begin
          errors++;
          $display("FAIL load_ready_pair: lsb got %b expected %b", load_ready_l, load_ready_m);
        end
        if (sout_valid_m && sout_ready) begin
          checks++;
          if (exp_m.size() == 0) begin
            errors++;
            $display("FAIL sb_msb: got bit %b expected no transfer", sout_m);
          end else begin
            e = exp_m.pop_front();
            if (sout_m !== e) begin
              errors++;
              $display("FAIL sb_msb: got %b expected %b at cycle %0d", sout_m, e, cyc);
            end
          end
          log_m = {log_m[14:0], sout_m};
          log_n++;
        end
        if (sout_valid_l && sout_ready) begin
          checks++;
          if (exp_l.size() == 0) begin
            errors++;
            $display("FAIL sb_lsb: got bit %b expected no transfer", sout_l);
          end else begin
            e = exp_l.pop_front();
            if (sout_l !== e) begin
              errors++;
              $display("FAIL sb_lsb: got %b expected %b at cycle %0d", sout_l, e, cyc);
            end
          end
          log_l = {log_l[14:0], sout_l};
        end
        if (done_m) done_log.push_back(cyc);
      end
    end
  endtask

  task automatic clear_logs();
    log_m = 16'h0000;
    log_l = 16'h0000;
    log_n = 0;
    done_log.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout_m, sout_valid_m, busy_m, done_m, load_ready_m} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {sout_m, sout_valid_m, busy_m, done_m, load_ready_m});
    end
    load_valid = 1'b1;
    d = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sout_valid_m, busy_m, load_ready_m, sout_valid_l} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 0000",
               {sout_valid_m, busy_m, load_ready_m, sout_valid_l});
    end
    load_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ready_m, sout_valid_m, busy_m, done_m} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 1000",
               {load_ready_m, sout_valid_m, busy_m, done_m});
    end
  endtask

  task automatic test_basic_msb();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'hA5; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; load_valid = 1'b0; d = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sout_valid_m, busy_m, done_m} !== 3'b110) begin
        errors++;
        $display("FAIL basic_flags bit%0d: got %b expected 110", k, {sout_valid_m, busy_m, done_m});
      end
      checks++;
      if (load_ready_m !== (k == 8)) begin
        errors++;
        $display("FAIL basic_load_ready bit%0d: got %b expected %b", k, load_ready_m, (k == 8));
      end
    end
    @(negedge clk);
    checks++;
    if ({done_m, sout_valid_m, busy_m, load_ready_m} !== 4'b1001) begin
      errors++;
      $display("FAIL basic_done: got %b expected 1001", {done_m, sout_valid_m, busy_m, load_ready_m});
    end
    @(negedge clk);
    checks++;
    if (done_m !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b expected 0", done_m);
    end
    @(posedge clk); #1;
    checks++;
    if (log_n != 8 || log_m[7:0] !== 8'hA5 || log_l[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_word: got n=%0d m=%h l=%h expected n=8 m=a5 l=a5", log_n, log_m[7:0], log_l[7:0]);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 8) begin
      errors++;
      $display("FAIL basic_done_cycle: got count %0d expected 1 at %0d", done_log.size(), c0 + 8);
    end
  endtask

  task automatic test_lsb_first();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'h80; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({sout_m, sout_l} !== 2'b10) begin
      errors++;
      $display("FAIL lsb_first_bit: got %b expected 10", {sout_m, sout_l});
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (log_n != 8 || log_m[7:0] !== 8'h80 || log_l[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL lsb_word: got n=%0d m=%h l=%h expected n=8 m=80 l=01", log_n, log_m[7:0], log_l[7:0]);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 8) begin
      errors++;
      $display("FAIL lsb_done: got count %0d expected 1 at %0d", done_log.size(), c0 + 8);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'hF0; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; load_valid = 1'b0; d = 8'h0F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({sout_m, sout_valid_m, busy_m, sout_l} !== 4'b1110) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: got %b expected 1110", k, {sout_m, sout_valid_m, busy_m, sout_l});
      end
    end
    @(posedge clk); #1;
    sout_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (log_n != 8 || log_m[7:0] !== 8'hF0 || log_l[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL bp_word: got n=%0d m=%h l=%h expected n=8 m=f0 l=0f", log_n, log_m[7:0], log_l[7:0]);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 11) begin
      errors++;
      $display("FAIL bp_done: got count %0d expected 1 at %0d", done_log.size(), c0 + 11);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'hFF; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; d = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sout_valid_m, load_ready_m} !== {1'b1, (k == 8)}) begin
        errors++;
        $display("FAIL b2b_first bit%0d: got %b expected %b", k, {sout_valid_m, load_ready_m}, {1'b1, (k == 8)});
      end
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({sout_valid_m, busy_m, done_m} !== {2'b11, (k == 1)}) begin
        errors++;
        $display("FAIL b2b_second bit%0d: got %b expected %b", k, {sout_valid_m, busy_m, done_m}, {2'b11, (k == 1)});
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (log_n != 16 || log_m !== 16'hFF00 || log_l !== 16'hFF00) begin
      errors++;
      $display("FAIL b2b_words: got n=%0d m=%h l=%h expected n=16 m=ff00 l=ff00", log_n, log_m, log_l);
    end
    checks++;
    if (done_log.size() != 2 || done_log[0] != c0 + 8 || done_log[1] != c0 + 16) begin
      errors++;
      $display("FAIL b2b_done: got count %0d expected 2 at %0d and %0d", done_log.size(), c0 + 8, c0 + 16);
    end
  endtask

  task automatic test_busy_ignore();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'h3C; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; load_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_valid = 1'b1; d = 8'hFF;
    @(negedge clk);
    checks++;
    if ({load_ready_m, sout_m} !== 2'b01) begin
      errors++;
      $display("FAIL ignore_ready: got %b expected 01", {load_ready_m, sout_m});
    end
    @(posedge clk); #1;
    load_valid = 1'b0; d = 8'h00;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (log_n != 8 || log_m[7:0] !== 8'h3C || log_l[7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL ignore_word: got n=%0d m=%h l=%h expected n=8 m=3c l=3c", log_n, log_m[7:0], log_l[7:0]);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 8 || sout_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: got done count %0d valid %b expected 1 and 0", done_log.size(), sout_valid_m);
    end
  endtask

  task automatic test_async_reset();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    d = 8'h5A; load_valid = 1'b1; sout_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sout_valid_m !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got valid %b expected 1", sout_valid_m);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout_valid_m, busy_m, done_m, load_ready_m, sout_m} !== 5'b00000) begin
      errors++;
      $display("FAIL areset_now: got %b expected 00000", {sout_valid_m, busy_m, done_m, load_ready_m, sout_m});
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_m.delete();
    exp_l.delete();
    clear_logs();
    @(negedge clk);
    checks++;
    if ({sout_valid_m, done_m, load_ready_m} !== 3'b001) begin
      errors++;
      $display("FAIL areset_release: got %b expected 001", {sout_valid_m, done_m, load_ready_m});
    end
    @(posedge clk); #1;
    d = 8'h81; load_valid = 1'b1;
    @(posedge clk); #1;
    c0 = cyc; load_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (log_n != 8 || log_m[7:0] !== 8'h81 || log_l[7:0] !== 8'h81) begin
      errors++;
      $display("FAIL areset_word: got n=%0d m=%h l=%h expected n=8 m=81 l=81", log_n, log_m[7:0], log_l[7:0]);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 8) begin
      errors++;
      $display("FAIL areset_done: got count %0d expected 1 at %0d", done_log.size(), c0 + 8);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic_msb();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_busy_ignore();
    test_async_reset();
    checks++;
    if (exp_m.size() != 0 || exp_l.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", exp_m.size(), exp_l.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_shift_out.md
Name: piso_shift_out

Overview:
Parallel-in/serial-out stage directly downstream of the team's 8-bit SR-flipflop register. It captures the register's parallel outputs (q0..q7 bundled as a vector) with a valid/ready load handshake. It then shifts them out one bit per accepted cycle under a serial valid/ready handshake. A counter and a small FSM track the bit position; back-to-back words run without a bubble.

Parameters:
WIDTH, 8, number of bits per word (min 2)
LSB_FIRST, 0, 0: d[0] (q0) sent first; 1: d[WIDTH-1] (q7) sent first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d  input  [0:WIDTH-1]  parallel word; d[0] is q0 of the upstream register
load_valid  input  1  d holds a word to capture
load_ready  output  1  block can accept a word this cycle
sout  output  1  current serial bit
sout_valid  output  1  sout is meaningful
sout_ready  input  1  downstream takes sout this cycle
busy  output  1  a word is in flight (state SHIFT)
done  output  1  one-cycle pulse after last bit of a word is accepted

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, immediate, no clock needed):
  - state=IDLE, shift reg=0, bit counter=0.
  - sout=0, sout_valid=0, busy=0, done=0.
  - load_ready forced 0 while rst_n low.
- State IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - On a rising edge with load_valid=1: capture d, counter=0, go to SHIFT.
- State SHIFT:
  - sout_valid=1, busy=1.
  - sout = captured bit at index cnt (LSB_FIRST=0) or WIDTH-1-cnt (LSB_FIRST=1).
  - Transfer occurs on an edge with sout_valid & sout_ready; each transfer increments cnt.
  - sout_ready=0 holds sout, cnt and the shift register unchanged; no timeout.
- Last bit (cnt==WIDTH-1) transferred:
  - done=1 in the next cycle, for exactly one cycle.
  - cnt wraps to 0.
  - If load_valid was also 1 on that edge: capture new d, stay in SHIFT. The next cycle shows the first bit of the new word: zero-bubble back-to-back.
  - Otherwise: go to IDLE.
- load_ready rule (combinational): (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & sout_ready).
  - load_valid when load_ready=0 is ignored and the word is not captured.
  - Upstream must hold d until accepted.
- Latency: load accepted at edge N → first bit valid in cycle N+1. With sout_ready held high, the last bit is in cycle N+WIDTH and done in cycle N+WIDTH+1.
- Counter width: clog2(WIDTH). Wrap only at WIDTH-1; values ≥ WIDTH are unreachable.
- All outputs are registered except load_ready.
- Reset mid-word: the word is discarded, no done pulse, and the block returns to IDLE at once. After release, the first edge with load_valid starts a fresh word.
- d changing while in SHIFT has no effect on sout.
- X/Z on d is captured as-is and is not checked.

Test Plan:
- Basic MSB order: reset, d=8'hA5, load_valid one cycle, sout_ready=1 → sout 1,0,1,0,0,1,0,1 over 8 cycles; done high on cycle 9 only; load_ready back to 1 in the cycle after the last bit.
- LSB_FIRST=1, d=8'hA5 → sout 1,0,1,0,0,1,0,1 reversed, i.e. d[7]..d[0] = 1,0,1,0,0,1,0,1. Also run d=8'h80 → seven 0s then a final 1.
- Backpressure: d=8'hF0, sout_ready low for 3 cycles after the 2nd bit → sout stays 1 and sout_valid stays 1 for those 3 cycles. Total sequence still 1,1,1,1,0,0,0,0; done after the 8th transfer.
- Back-to-back: d=8'hFF then 8'h00, load_valid high continuously → 16 consecutive valid bits (eight 1s, eight 0s) with no gap; done pulses twice, 8 cycles apart.
- Busy-load ignore: load 8'h3C, assert load_valid with d=8'hFF at bit 3 (load_ready=0) → output remains 0,0,1,1,1,1,0,0; the 8'hFF word is not captured.
- Async reset mid-word: drop rst_n between edges at bit 4 → sout_valid, busy and done go 0 immediately. After release, loading 8'h81 gives 1,0,0,0,0,0,0,1.
